// File: rtl/ms_pkg.sv
// Shared definitions for the minesweeper grid datapath: state encoding, LFSR
// constants and the neighbour-count helper.
package ms_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StPlace  = 3'd1;
    localparam logic [2:0] StReady  = 3'd2;
    localparam logic [2:0] StDecode = 3'd3;
    localparam logic [2:0] StEval   = 3'd4;
    localparam logic [2:0] StOver   = 3'd5;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting left
    localparam logic [15:0] LfsrTaps        = 16'hB400;
    localparam logic [15:0] LfsrSeedDefault = 16'hACE1;
    localparam int          MaxCells        = 1024;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], ^(q & LfsrTaps)};
    endfunction

    // Mines among the up-to-8 neighbours of (r,c); edges do not wrap
    function automatic logic [3:0] count_nearby(input logic [MaxCells-1:0] m,
                                                input int rows, input int cols,
                                                input int r, input int c);
        logic [3:0] n;
        logic [9:0] bi;
        int         rr;
        int         cc;
        n  = '0;
        bi = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if ((dr != 0 || dc != 0) && rr >= 0 && rr < rows && cc >= 0 && cc < cols) begin
                    bi = 10'(rr * cols + cc);
                    n  = n + {3'b000, m[bi]};
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ms_lfsr16.sv
// 16-bit Fibonacci LFSR used for random mine placement; a zero seed falls back
// to the default seed so the register can never lock up.
module ms_lfsr16
    import ms_pkg::*;
(
    input  logic        clka,
    input  logic        restart,
    input  logic        load_seed,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_seed) begin
            q_d = (seed == 16'h0000) ? LfsrSeedDefault : seed;
        end else if (step) begin
            q_d = lfsr_step(q_q);
        end
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            q_q <= LfsrSeedDefault;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ms_grid_dp.sv
// Minesweeper grid datapath: mine placement (preset or LFSR), move decode and
// evaluation, win/loss tracking and a saturating win counter.
module ms_grid_dp
    import ms_pkg::*;
#(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int NUM_MINES = 3,
    localparam int N        = ROWS * COLS,
    localparam int IDX_W    = $clog2(N)
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic             preset_en,
    input  logic [N-1:0]     preset_mines,
    input  logic             load,
    input  logic [IDX_W-1:0] data,
    input  logic             mode,
    output logic             place_done,
    output logic             alu_done,
    output logic             err,
    output logic             gameover,
    output logic             win,
    output logic [N-1:0]     mines,
    output logic [N-1:0]     cleared,
    output logic [N-1:0]     flagged,
    output logic [3:0]       n_nearby,
    output logic [31:0]      global_score
);

    localparam int CNT_W = $clog2(N + 1);

    logic [2:0]       state_q, state_d;
    logic             preset_q, preset_d;
    logic [N-1:0]     mines_q, mines_d;
    logic [N-1:0]     cleared_q, cleared_d;
    logic [N-1:0]     flagged_q, flagged_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             gameover_q, gameover_d;
    logic             win_q, win_d;
    logic [3:0]       n_nearby_q, n_nearby_d;
    logic [31:0]      score_q, score_d;
    logic             place_done_q, place_done_d;
    logic             alu_done_q, alu_done_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             lfsr_load;
    logic             lfsr_step_en;
    logic [15:0]      lfsr_q;
    logic [IDX_W-1:0] cand;
    logic             start_ok;

    ms_lfsr16 u_lfsr (
        .clka      (clka),
        .restart   (restart),
        .load_seed (lfsr_load),
        .seed      (seed),
        .step      (lfsr_step_en),
        .q         (lfsr_q)
    );

    // Candidate comes from the value the LFSR steps to in this PLACE cycle
    assign cand     = IDX_W'(lfsr_step(lfsr_q));
    assign start_ok = start && (state_q inside {StIdle, StReady, StOver});

    always_comb begin
        state_d      = state_q;
        preset_d     = preset_q;
        mines_d      = mines_q;
        cleared_d    = cleared_q;
        flagged_d    = flagged_q;
        onehot_d     = onehot_q;
        gameover_d   = gameover_q;
        win_d        = win_q;
        n_nearby_d   = n_nearby_q;
        score_d      = score_q;
        idx_d        = idx_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        place_done_d = 1'b0;
        alu_done_d   = 1'b0;
        err_d        = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;

        if (start_ok) begin
            mines_d    = preset_en ? preset_mines : '0;
            cleared_d  = '0;
            flagged_d  = '0;
            gameover_d = 1'b0;
            win_d      = 1'b0;
            n_nearby_d = '0;
            cnt_d      = '0;
            preset_d   = preset_en;
            lfsr_load  = !preset_en;
            state_d    = StPlace;
        end else begin
            case (state_q)
                StPlace: begin
                    if (preset_q) begin
                        place_done_d = 1'b1;
                        state_d      = StReady;
                    end else begin
                        lfsr_step_en = 1'b1;
                        if (int'(cand) < N && !mines_q[cand]) begin
                            mines_d[cand] = 1'b1;
                            cnt_d         = cnt_q + CNT_W'(1);
                            if (int'(cnt_q) + 1 == NUM_MINES) begin
                                place_done_d = 1'b1;
                                state_d      = StReady;
                            end
                        end
                    end
                end
                StReady: begin
                    if (load) begin
                        idx_d   = data;
                        mode_d  = mode;
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    if (int'(idx_q) >= N) begin
                        err_d   = 1'b1;
                        state_d = StReady;
                    end else begin
                        onehot_d        = '0;
                        onehot_d[idx_q] = 1'b1;
                        state_d         = StEval;
                    end
                end
                StEval: begin
                    alu_done_d = 1'b1;
                    if (mode_q) begin
                        if (!(|(cleared_q & onehot_q))) begin
                            flagged_d = flagged_q ^ onehot_q;
                        end
                    end else if (!(|((cleared_q | flagged_q) & onehot_q))) begin
                        cleared_d  = cleared_q | onehot_q;
                        n_nearby_d = count_nearby(MaxCells'(mines_q), ROWS, COLS,
                                                  int'(idx_q) / COLS, int'(idx_q) % COLS);
                        if (|(mines_q & onehot_q)) begin
                            gameover_d = 1'b1;
                        end else if (cleared_d == ~mines_q) begin
                            win_d      = 1'b1;
                            gameover_d = 1'b1;
                            if (score_q != 32'hFFFF_FFFF) begin
                                score_d = score_q + 32'd1;
                            end
                        end
                    end
                    state_d = gameover_d ? StOver : StReady;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q      <= StIdle;
            preset_q     <= 1'b0;
            mines_q      <= '0;
            cleared_q    <= '0;
            flagged_q    <= '0;
            onehot_q     <= '0;
            gameover_q   <= 1'b0;
            win_q        <= 1'b0;
            n_nearby_q   <= '0;
            score_q      <= '0;
            place_done_q <= 1'b0;
            alu_done_q   <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            mode_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            preset_q     <= preset_d;
            mines_q      <= mines_d;
            cleared_q    <= cleared_d;
            flagged_q    <= flagged_d;
            onehot_q     <= onehot_d;
            gameover_q   <= gameover_d;
            win_q        <= win_d;
            n_nearby_q   <= n_nearby_d;
            score_q      <= score_d;
            place_done_q <= place_done_d;
            alu_done_q   <= alu_done_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
        end
    end

    assign place_done   = place_done_q;
    assign alu_done     = alu_done_q;
    assign err          = err_q;
    assign gameover     = gameover_q;
    assign win          = win_q;
    assign mines        = mines_q;
    assign cleared      = cleared_q;
    assign flagged      = flagged_q;
    assign n_nearby     = n_nearby_q;
    assign global_score = score_q;

endmodule

// File: tb/tb_ms_grid_dp.sv
// Scoreboard bench for ms_grid_dp on a 5x5 board: stimulus pushes expected
// responses, a negedge monitor pops and compares on every output pulse.
module tb_ms_grid_dp;

    localparam logic [1:0] KPlace = 2'd0;
    localparam logic [1:0] KAlu   = 2'd1;
    localparam logic [1:0] KErr   = 2'd2;
    localparam logic [24:0] Preset = 25'h0001104;  // mines at 2, 8, 12

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  nn;
        logic        go;
        logic        win;
        logic [31:0] score;
        logic [24:0] cl;
        logic [24:0] fl;
        logic        chk_m;
        logic [24:0] m;
    } exp_t;

    logic        clk;
    logic        restart;
    logic        start;
    logic [15:0] seed;
    logic        preset_en;
    logic [24:0] preset_mines;
    logic        load;
    logic [4:0]  data;
    logic        mode;
    logic        place_done;
    logic        alu_done;
    logic        err;
    logic        gameover;
    logic        win;
    logic [24:0] mines;
    logic [24:0] cleared;
    logic [24:0] flagged;
    logic [3:0]  n_nearby;
    logic [31:0] global_score;

    ms_grid_dp #(.ROWS(5), .COLS(5), .NUM_MINES(3)) dut (
        .clka         (clk),
        .restart      (restart),
        .start        (start),
        .seed         (seed),
        .preset_en    (preset_en),
        .preset_mines (preset_mines),
        .load         (load),
        .data         (data),
        .mode         (mode),
        .place_done   (place_done),
        .alu_done     (alu_done),
        .err          (err),
        .gameover     (gameover),
        .win          (win),
        .mines        (mines),
        .cleared      (cleared),
        .flagged      (flagged),
        .n_nearby     (n_nearby),
        .global_score (global_score)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_vec  = 0;
    int   n_fail = 0;
    int   place_cnt = 0;
    int   alu_cnt   = 0;
    exp_t sb[$];

    // Hand-computed neighbour counts for the preset board
    logic [3:0] nn_tab [25] = '{0, 1, 1, 2, 1,
                                0, 2, 3, 2, 1,
                                0, 1, 1, 2, 1,
                                0, 1, 1, 1, 0,
                                0, 0, 0, 0, 0};

    logic [24:0] exp_mines, exp_cl, exp_fl;
    logic        exp_go, exp_win;
    logic [3:0]  exp_nn;
    logic [31:0] exp_score;

    exp_t       mon_e;
    logic [1:0] mon_k;

    always @(negedge clk) begin
        if (place_done || alu_done || err) begin
            mon_k = place_done ? KPlace : (alu_done ? KAlu : KErr);
            if (place_done) place_cnt++;
            if (alu_done) alu_cnt++;
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got kind %0d at %0t, required no pulse", mon_k, $time);
            end else begin
                mon_e = sb.pop_front();
                if (mon_k != mon_e.kind || n_nearby != mon_e.nn || gameover != mon_e.go ||
                    win != mon_e.win || global_score != mon_e.score || cleared != mon_e.cl ||
                    flagged != mon_e.fl || (mon_e.chk_m && mines != mon_e.m)) begin
                    n_fail++;
                    $display("FAIL response@%0t: got kind=%0d nn=%0d go=%b win=%b score=%0d cl=%h fl=%h m=%h; required kind=%0d nn=%0d go=%b win=%b score=%0d cl=%h fl=%h m=%h(chk=%b)",
                             $time, mon_k, n_nearby, gameover, win, global_score, cleared, flagged, mines,
                             mon_e.kind, mon_e.nn, mon_e.go, mon_e.win, mon_e.score, mon_e.cl,
                             mon_e.fl, mon_e.m, mon_e.chk_m);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({place_done, alu_done, err, gameover, win, n_nearby, global_score}), 64'd0);
        check({name, "_board"}, 64'({mines, cleared, flagged} != 75'd0), 64'd0);
    endtask

    task automatic push(input logic [1:0] kind, input logic chk_m);
        exp_t e;
        e.kind = kind; e.nn = exp_nn; e.go = exp_go; e.win = exp_win; e.score = exp_score;
        e.cl = exp_cl; e.fl = exp_fl; e.chk_m = chk_m; e.m = exp_mines;
        sb.push_back(e);
    endtask

    task automatic wait_place();
        int  c0;
        bit  ok;
        c0 = place_cnt;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (place_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL place_timeout: got no place_done in 400 cycles, required one");
        end
    endtask

    task automatic new_game(input logic pre, input logic [15:0] sd);
        exp_cl = '0; exp_fl = '0; exp_go = 1'b0; exp_win = 1'b0; exp_nn = '0;
        exp_mines = Preset;
        push(KPlace, pre);
        @(posedge clk); #1;
        start = 1'b1; preset_en = pre; preset_mines = Preset; seed = sd;
        @(posedge clk); #1;
        start = 1'b0;
        wait_place();
    endtask

    task automatic move(input int idx, input logic m);
        if (exp_go) begin
            // game over: load must be ignored, nothing expected
        end else if (idx >= 25) begin
            push(KErr, 1'b0);
        end else if (m) begin
            if (!exp_cl[idx]) exp_fl[idx] = ~exp_fl[idx];
            push(KAlu, 1'b0);
        end else if (exp_cl[idx] || exp_fl[idx]) begin
            push(KAlu, 1'b0);
        end else begin
            exp_cl[idx] = 1'b1;
            exp_nn = nn_tab[idx];
            if (exp_mines[idx]) begin
                exp_go = 1'b1;
            end else if (exp_cl == ~exp_mines) begin
                exp_go = 1'b1;
                exp_win = 1'b1;
                exp_score = exp_score + 32'd1;
            end
            push(KAlu, 1'b0);
        end
        @(posedge clk); #1;
        load = 1'b1; data = 5'(idx); mode = m;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic clear_all_safe();
        for (int i = 0; i < 25; i++) begin
            if (!Preset[i]) move(i, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    logic [24:0] map1;
    int          pc;
    int          ac;

    initial begin
        restart = 1'b1; start = 1'b0; seed = '0; preset_en = 1'b0; preset_mines = '0;
        load = 1'b0; data = '0; mode = 1'b0;
        exp_score = '0;
        repeat (3) @(posedge clk); #1;
        restart = 1'b0;
        check_zero("reset_state");

        // Game 1: reveal 7 then hit mine 12; further loads ignored
        new_game(1'b1, 16'h0);
        move(7, 1'b0);
        move(12, 1'b0);
        #1;
        check("g1_gameover", 64'(gameover), 64'd1);
        check("g1_win", 64'(win), 64'd0);
        ac = alu_cnt;
        move(3, 1'b0);
        check("g1_load_in_over", 64'(alu_cnt), 64'(ac));

        // Game 2: bad index, flag interplay, then full clear
        new_game(1'b1, 16'h0);
        move(25, 1'b0);
        move(2, 1'b1);
        move(2, 1'b0);
        move(2, 1'b1);
        clear_all_safe();
        #1;
        check("g2_score", 64'(global_score), 64'd1);
        check("g2_win", 64'({win, gameover}), 64'b11);

        // Game 3: second win keeps counting
        new_game(1'b1, 16'h0);
        clear_all_safe();
        #1;
        check("g3_score", 64'(global_score), 64'd2);

        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        exp_score = '0;
        check_zero("restart_after_wins");

        // LFSR placement with seed 0, twice
        pc = place_cnt;
        new_game(1'b0, 16'h0000);
        map1 = mines;
        check("lfsr_mine_count", 64'($countones(map1)), 64'd3);
        repeat (10) @(posedge clk);
        check("lfsr_place_once", 64'(place_cnt), 64'(pc + 1));
        new_game(1'b0, 16'h0000);
        check("lfsr_repeat_map", 64'(mines), 64'(map1));

        // Restart mid-PLACE
        @(posedge clk); #1;
        start = 1'b1; preset_en = 1'b0; seed = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0; restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        check_zero("restart_mid_place");
        pc = place_cnt;
        repeat (40) @(posedge clk);
        check("no_place_after_restart", 64'(place_cnt), 64'(pc));

        // Restart mid-EVAL
        new_game(1'b1, 16'h0);
        @(posedge clk); #1;
        load = 1'b1; data = 5'd7; mode = 1'b0;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        restart = 1'b1;
        ac = alu_cnt;
        @(posedge clk); #1;
        restart = 1'b0;
        check_zero("restart_mid_eval");
        repeat (5) @(posedge clk);
        check("no_alu_after_restart", 64'(alu_cnt), 64'(ac));

        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
